mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 11 +
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    StArb,
    StLocked
  } arb_state_e;

  localparam int unsigned MaxExtWait = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between the CPU and an ext
// (loader/debug) port, with starvation protection and exclusive ext locking.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = 18,
  parameter int unsigned WORD_SIZE    = 18,
  parameter int unsigned MAX_EXT_WAIT = MaxExtWait
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_stall,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_rvalid,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [ADDR_SIZE-1:0] ext_addr,
  input  logic [WORD_SIZE-1:0] ext_wdata,
  input  logic                 ext_lock,
  output logic                 ext_gnt,
  output logic [WORD_SIZE-1:0] ext_rdata,
  output logic                 ext_rvalid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  // Wide enough to hold MAX_EXT_WAIT, and at least one bit when it is zero.
  localparam int unsigned CntW = $clog2(MAX_EXT_WAIT + 2);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            cpu_rvalid_q, cpu_rvalid_d;
  logic            ext_rvalid_q, ext_rvalid_d;
  logic            cpu_gnt, ext_gnt_w, wait_full;

  assign wait_full = (wait_cnt_q == CntW'(MAX_EXT_WAIT));

  always_comb begin
    state_d   = state_q;
    cpu_gnt   = 1'b0;
    ext_gnt_w = 1'b0;
    if (reset) begin
      unique case (state_q)
        StArb: begin
          if (cpu_req && !(ext_req && wait_full)) begin
            cpu_gnt = 1'b1;
          end else if (ext_req) begin
            ext_gnt_w = 1'b1;
          end
          if (ext_gnt_w && ext_lock) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          ext_gnt_w = ext_req;
          // The release cycle is still served as locked.
          if (!ext_lock) begin
            state_d = StArb;
          end
        end
        default: state_d = StArb;
      endcase
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ext_req || ext_gnt_w) begin
      wait_cnt_d = '0;
    end else if (!wait_full) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  assign cpu_rvalid_d = cpu_gnt & ~cpu_we;
  assign ext_rvalid_d = ext_gnt_w & ~ext_we;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StArb;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    if (ext_gnt_w) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
    end else if (cpu_gnt) begin
      mem_we = cpu_we;
    end
  end

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign ext_gnt    = ext_gnt_w;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural
// single-port memory (one-cycle read latency).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 18;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ext_req, ext_we, ext_lock;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [1024];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_lock   (ext_lock),
    .ext_gnt    (ext_gnt),
    .ext_rdata  (ext_rdata),
    .ext_rvalid (ext_rvalid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Location 0x10 is preloaded while reset is held.
  always @(posedge clock) begin
    if (!reset) begin
      mem[16] <= 18'h0ABCD;
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_lock = 0;
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    tick();
    // No grants while reset is low.
    cpu_req = 1; ext_req = 1;
    #1;
    chk("rst_ext_gnt", 32'(ext_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_cpu_stall", 32'(cpu_stall), 1);
    tick();
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_ext_rvalid", 32'(ext_rvalid), 0);
    chk("rst_state", 32'(dut.state_q), 32'(StArb));
    idle_inputs();
    reset = 1;
    tick();

    // CPU read of preloaded location.
    cpu_req = 1; cpu_addr = 18'h00010;
    #1;
    chk("rd_mem_addr", 32'(mem_addr), 32'h10);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_cpu_stall", 32'(cpu_stall), 0);
    tick();
    cpu_req = 0;
    #1;
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h0ABCD);
    tick();

    // Starvation protection: both requesting for 6 cycles.
    cpu_req = 1; cpu_addr = 18'h00010;
    ext_req = 1; ext_addr = 18'h00020;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk($sformatf("fair_ext_gnt_c%0d", c), 32'(ext_gnt), 32'(c == 5));
      chk($sformatf("fair_stall_c%0d", c), 32'(cpu_stall), 32'(c == 5));
      chk($sformatf("fair_addr_c%0d", c), 32'(mem_addr), (c == 5) ? 32'h20 : 32'h10);
      if (c > 1) begin
        chk($sformatf("fair_cpu_rv_c%0d", c), 32'(cpu_rvalid), 32'(c != 6));
        chk($sformatf("fair_ext_rv_c%0d", c), 32'(ext_rvalid), 32'(c == 6));
      end
      tick();
    end
    idle_inputs();
    tick();

    // Ext write followed immediately by CPU read of the same address.
    ext_req = 1; ext_we = 1; ext_addr = 18'h00020; ext_wdata = 18'h12345;
    #1;
    chk("wr_ext_gnt", 32'(ext_gnt), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h20);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h12345);
    tick();
    idle_inputs();
    cpu_req = 1; cpu_addr = 18'h00020;
    #1;
    chk("wr_ext_rvalid", 32'(ext_rvalid), 0);
    chk("wr_cpu_stall", 32'(cpu_stall), 0);
    tick();
    cpu_req = 0;
    #1;
    chk("wr_rd_rvalid", 32'(cpu_rvalid), 1);
    chk("wr_rd_rdata", 32'(cpu_rdata), 32'h12345);
    tick();

    // Locked ext write, CPU locked out until release.
    ext_req = 1; ext_we = 1; ext_lock = 1; ext_addr = 18'h00100; ext_wdata = 18'h2AAAA;
    #1;
    chk("lk_ext_gnt", 32'(ext_gnt), 1);
    tick();
    ext_req = 0; ext_we = 0;
    cpu_req = 1; cpu_addr = 18'h00100;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("lk_stall_c%0d", c), 32'(cpu_stall), 1);
      chk($sformatf("lk_mem_we_c%0d", c), 32'(mem_we), 0);
      chk($sformatf("lk_state_c%0d", c), 32'(dut.state_q), 32'(StLocked));
      tick();
    end
    ext_lock = 0;
    #1;
    chk("lk_release_stall", 32'(cpu_stall), 1);
    tick();
    #1;
    chk("lk_after_stall", 32'(cpu_stall), 0);
    chk("lk_after_addr", 32'(mem_addr), 32'h100);
    tick();
    cpu_req = 0;
    #1;
    chk("lk_rd_rvalid", 32'(cpu_rvalid), 1);
    chk("lk_rd_rdata", 32'(cpu_rdata), 32'h2AAAA);
    tick();

    // Reset while locked with an ext read in flight.
    ext_req = 1; ext_lock = 1; ext_addr = 18'h00020;
    #1;
    chk("rl_gnt_a", 32'(ext_gnt), 1);
    tick();
    #1;
    chk("rl_gnt_b", 32'(ext_gnt), 1);
    chk("rl_rvalid_b", 32'(ext_rvalid), 1);
    tick();
    reset = 0; cpu_req = 1; cpu_addr = 18'h00010;
    #1;
    chk("rl_rst_gnt", 32'(ext_gnt), 0);
    chk("rl_rst_stall", 32'(cpu_stall), 1);
    chk("rl_rst_we", 32'(mem_we), 0);
    tick();
    reset = 1;
    #1;
    chk("rl_ext_rvalid", 32'(ext_rvalid), 0);
    chk("rl_state", 32'(dut.state_q), 32'(StArb));
    chk("rl_cpu_first", 32'(cpu_stall), 0);
    chk("rl_ext_denied", 32'(ext_gnt), 0);
    tick();
    idle_inputs();
    tick();

    // Quiet bus.
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("idle_we_%0d", c), 32'(mem_we), 0);
      chk($sformatf("idle_cpu_rv_%0d", c), 32'(cpu_rvalid), 0);
      chk($sformatf("idle_ext_rv_%0d", c), 32'(ext_rvalid), 0);
      chk($sformatf("idle_wait_%0d", c), 32'(dut.wait_cnt_q), 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
